// File: rtl/control_sequencer.sv
// Purpose: hardwired control unit. It fetches an instruction through the shared bus,
//          then steps the ALU3 / MULDIV / UNARY execute sequence that the opcode in ir selects.
// Latency: one state per clk. NOP takes 4 cycles, UNARY 5, ALU3 6 and MULDIV 7 (T0 to next T0).
// Backpressure: stop is sampled only at instruction end. It parks the unit in PAUSE until it drops.
// Ports:
//   clk, clr (async active-high reset); ir[31:0] instruction (opcode/Ra/Rb/Rc); stop pause request
//   PCout..LOin single-bit datapath strobes; alu_op[4:0]; reg_in/reg_out one-hot register enables;
//   run high whenever the sequencer is neither in reset nor halted.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        incPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  alu_op,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        run
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_PAUSE = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu3;
    logic       is_muldiv;
    logic       is_unary;
    logic       is_halt;
    logic       unused_ir_low;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];

    // Immediate/constant field is not consumed by the control path.
    assign unused_ir_low = ^ir[14:0];

    assign is_alu3   = (opcode >= 5'b00011) && (opcode <= 5'b01011);
    assign is_muldiv = (opcode == 5'b01110) || (opcode == 5'b01111);
    assign is_unary  = (opcode == 5'b10000) || (opcode == 5'b10001);
    assign is_halt   = (opcode == 5'b11011);

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        onehot = 16'h0001 << idx;
    endfunction

    // State register: clr forces RESET immediately, so the decoded outputs drop without a clock.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The instruction class is consulted only from T3 on, when ir is valid.
    always_comb begin
        state_t end_state;
        end_state = stop ? S_PAUSE : S_T0;
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_T0;
            S_T0:    state_nxt = S_T1;
            S_T1:    state_nxt = S_T2;
            S_T2:    state_nxt = S_T3;
            S_T3: begin
                if (is_halt) begin
                    state_nxt = S_HALT;
                end else if (is_alu3 || is_muldiv || is_unary) begin
                    state_nxt = S_T4;
                end else begin
                    state_nxt = end_state;
                end
            end
            S_T4:    state_nxt = is_unary ? end_state : S_T5;
            S_T5:    state_nxt = is_muldiv ? S_T6 : end_state;
            S_T6:    state_nxt = end_state;
            S_PAUSE: state_nxt = stop ? S_PAUSE : S_T0;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
    end

    // Moore output decode from state and the held instruction.
    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        incPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = 5'b00000;
        reg_in   = 16'h0000;
        reg_out  = 16'h0000;
        run      = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                incPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu3) begin
                    reg_out = onehot(rb);
                    Yin     = 1'b1;
                end else if (is_muldiv) begin
                    reg_out = onehot(ra);
                    Yin     = 1'b1;
                end else if (is_unary) begin
                    reg_out = onehot(rb);
                    alu_op  = opcode;
                    Zin     = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    reg_out = onehot(rc);
                    alu_op  = opcode;
                    Zin     = 1'b1;
                end else if (is_muldiv) begin
                    reg_out = onehot(rb);
                    alu_op  = opcode;
                    Zin     = 1'b1;
                end else if (is_unary) begin
                    ZLowOut = 1'b1;
                    reg_in  = onehot(ra);
                end
            end
            S_T5: begin
                if (is_alu3) begin
                    ZLowOut = 1'b1;
                    reg_in  = onehot(ra);
                end else if (is_muldiv) begin
                    ZLowOut = 1'b1;
                    LOin    = 1'b1;
                end
            end
            S_T6: begin
                ZHighOut = 1'b1;
                HIin     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Stimulus pushes a cycle-stamped expected output vector
// into a queue. A negedge monitor pops each entry and compares it in its cycle.
`timescale 1ns/1ps
module tb_control_sequencer;

    typedef logic [51:0] ctl_t;

    localparam logic [13:0] F_PCOUT  = 14'h2000;
    localparam logic [13:0] F_PCIN   = 14'h1000;
    localparam logic [13:0] F_INCPC  = 14'h0800;
    localparam logic [13:0] F_MARIN  = 14'h0400;
    localparam logic [13:0] F_READ   = 14'h0200;
    localparam logic [13:0] F_MDRIN  = 14'h0100;
    localparam logic [13:0] F_MDROUT = 14'h0080;
    localparam logic [13:0] F_IRIN   = 14'h0040;
    localparam logic [13:0] F_YIN    = 14'h0020;
    localparam logic [13:0] F_ZIN    = 14'h0010;
    localparam logic [13:0] F_ZLO    = 14'h0008;
    localparam logic [13:0] F_ZHI    = 14'h0004;
    localparam logic [13:0] F_HIIN   = 14'h0002;
    localparam logic [13:0] F_LOIN   = 14'h0001;
    localparam logic [13:0] F_NONE   = 14'h0000;
    localparam ctl_t        ZERO     = '0;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        stop;
    logic        PCout, PCin, incPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [4:0]  alu_op;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        run;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop),
        .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
        .alu_op(alu_op), .reg_in(reg_in), .reg_out(reg_out), .run(run)
    );

    always #5 clk = ~clk;

    ctl_t act;
    assign act = {PCout, PCin, incPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                  ZLowOut, ZHighOut, HIin, LOin, alu_op, reg_in, reg_out, run};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    q_cyc[$];
    ctl_t  q_val[$];
    string q_name[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  done = 1'b0;
    int    t0;

    function automatic ctl_t mk(input logic [13:0] f, input logic [4:0] a,
                                input logic [15:0] ri, input logic [15:0] ro, input logic r);
        return {f, a, ri, ro, r};
    endfunction

    task automatic push(input int at, input ctl_t v, input string nm);
        q_cyc.push_back(at);
        q_val.push_back(v);
        q_name.push_back(nm);
    endtask

    task automatic fetch(input int t);
        push(t,     mk(F_PCOUT | F_MARIN | F_INCPC | F_ZIN, 5'b0, 16'h0, 16'h0, 1'b1), "fetch_t0");
        push(t + 1, mk(F_ZLO | F_PCIN | F_READ | F_MDRIN,   5'b0, 16'h0, 16'h0, 1'b1), "fetch_t1");
        push(t + 2, mk(F_MDROUT | F_IRIN,                   5'b0, 16'h0, 16'h0, 1'b1), "fetch_t2");
    endtask

    // Advance to just after the rising edge that starts cycle c. This always terminates.
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare each expectation in its own cycle. Stale or unreached entries are failures.
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            n_cmp++;
            if (q_cyc[0] < cyc) begin
                n_err++;
                $display("FAIL %s: expected at cycle %0d, not checked until %0d", q_name[0], q_cyc[0], cyc);
            end else if (act !== q_val[0]) begin
                n_err++;
                $display("FAIL %s @cycle %0d: got %h required %h", q_name[0], cyc, act, q_val[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_val.pop_front());
            void'(q_name.pop_front());
        end
        if (done) begin
            while (q_cyc.size() > 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: cycle %0d never reached", q_name[0], q_cyc[0]);
                void'(q_cyc.pop_front());
                void'(q_val.pop_front());
                void'(q_name.pop_front());
            end
        end
    end

    initial begin
        clr  = 1'b1;
        stop = 1'b0;
        ir   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        push(cyc, ZERO, "reset_state");
        clr = 1'b0;
        t0  = cyc + 1;

        // AND r1 = r2 & r3
        ir = 32'h5091_8000;
        fetch(t0);
        push(t0 + 3, mk(F_YIN, 5'b0,     16'h0,    16'h0004, 1'b1), "and_t3");
        push(t0 + 4, mk(F_ZIN, 5'b01010, 16'h0,    16'h0008, 1'b1), "and_t4");
        push(t0 + 5, mk(F_ZLO, 5'b0,     16'h0002, 16'h0,    1'b1), "and_t5");
        t0 += 6;
        wait_cyc(t0);

        // MUL Ra=4, Rb=5. A halt opcode is on ir during T0/T1 and must not matter.
        ir = 32'hD800_0000;
        fetch(t0);
        push(t0 + 3, mk(F_YIN,          5'b0,     16'h0, 16'h0010, 1'b1), "mul_t3");
        push(t0 + 4, mk(F_ZIN,          5'b01110, 16'h0, 16'h0020, 1'b1), "mul_t4");
        push(t0 + 5, mk(F_ZLO | F_LOIN, 5'b0,     16'h0, 16'h0,    1'b1), "mul_t5");
        push(t0 + 6, mk(F_ZHI | F_HIIN, 5'b0,     16'h0, 16'h0,    1'b1), "mul_t6");
        wait_cyc(t0 + 2);
        ir = 32'h7228_0000;
        t0 += 7;
        wait_cyc(t0);

        // NEG r0 = -r15: register index 0 and 15
        ir = 32'h8078_0000;
        fetch(t0);
        push(t0 + 3, mk(F_ZIN, 5'b10000, 16'h0,    16'h8000, 1'b1), "neg_t3");
        push(t0 + 4, mk(F_ZLO, 5'b0,     16'h0001, 16'h0,    1'b1), "neg_t4");
        t0 += 5;
        wait_cyc(t0);

        // Unknown opcode 11111 behaves as a NOP
        ir = 32'hF800_0000;
        fetch(t0);
        push(t0 + 3, mk(F_NONE, 5'b0, 16'h0, 16'h0, 1'b1), "nop11111_t3");
        t0 += 4;
        wait_cyc(t0);

        // Opcode 01100 sits just past the ALU3 range and is a NOP
        ir = 32'h6000_0000;
        fetch(t0);
        push(t0 + 3, mk(F_NONE, 5'b0, 16'h0, 16'h0, 1'b1), "nop01100_t3");
        t0 += 4;
        wait_cyc(t0);

        // ALU3 lowest opcode 00011: Ra=15, Rb=0, Rc=7
        ir = 32'h1F83_8000;
        fetch(t0);
        push(t0 + 3, mk(F_YIN, 5'b0,     16'h0,    16'h0001, 1'b1), "op3_t3");
        push(t0 + 4, mk(F_ZIN, 5'b00011, 16'h0,    16'h0080, 1'b1), "op3_t4");
        push(t0 + 5, mk(F_ZLO, 5'b0,     16'h8000, 16'h0,    1'b1), "op3_t5");
        t0 += 6;
        wait_cyc(t0);

        // Pause: stop rises in T4 and holds so that PAUSE lasts exactly 3 cycles
        ir = 32'h5091_8000;
        fetch(t0);
        push(t0 + 3, mk(F_YIN, 5'b0,     16'h0,    16'h0004, 1'b1), "pz_t3");
        push(t0 + 4, mk(F_ZIN, 5'b01010, 16'h0,    16'h0008, 1'b1), "pz_t4");
        push(t0 + 5, mk(F_ZLO, 5'b0,     16'h0002, 16'h0,    1'b1), "pz_t5");
        push(t0 + 6, mk(F_NONE, 5'b0, 16'h0, 16'h0, 1'b1), "pause1");
        push(t0 + 7, mk(F_NONE, 5'b0, 16'h0, 16'h0, 1'b1), "pause2");
        push(t0 + 8, mk(F_NONE, 5'b0, 16'h0, 16'h0, 1'b1), "pause3");
        wait_cyc(t0 + 4);
        stop = 1'b1;
        wait_cyc(t0 + 8);
        stop = 1'b0;
        t0 += 9;
        wait_cyc(t0);

        // clr pulsed asynchronously in mid-T4 of an ALU3
        ir = 32'h5091_8000;
        fetch(t0);
        push(t0 + 3, mk(F_YIN, 5'b0, 16'h0, 16'h0004, 1'b1), "clr_t3");
        push(t0 + 4, ZERO, "clr_async_t4");
        push(t0 + 5, ZERO, "clr_held");
        wait_cyc(t0 + 4);
        #2;
        clr = 1'b1;
        wait_cyc(t0 + 5);
        clr = 1'b0;
        t0 += 6;
        wait_cyc(t0);

        // HALT: stop toggling is ignored and only clr leaves
        ir = 32'hD800_0000;
        fetch(t0);
        push(t0 + 3, mk(F_NONE, 5'b0, 16'h0, 16'h0, 1'b1), "halt_t3");
        for (int k = 4; k <= 10; k++) push(t0 + k, ZERO, "halted");
        wait_cyc(t0 + 5);
        stop = 1'b1;
        wait_cyc(t0 + 6);
        stop = 1'b0;
        wait_cyc(t0 + 7);
        stop = 1'b1;
        wait_cyc(t0 + 9);
        stop = 1'b0;
        wait_cyc(t0 + 10);
        clr = 1'b1;
        wait_cyc(t0 + 11);
        clr = 1'b0;
        ir  = 32'hF800_0000;
        t0 += 12;
        fetch(t0);
        wait_cyc(t0 + 3);

        @(negedge clk);
        done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
